mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one 256-bit line memory between the I and D caches
module mem_arbiter (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_enable_i,
    input  logic         i_write_i,
    input  logic [31:0]  i_addr_i,
    input  logic [255:0] i_data_i,
    output logic [255:0] i_data_o,
    output logic         i_ack_o,
    input  logic         d_enable_i,
    input  logic         d_write_i,
    input  logic [31:0]  d_addr_i,
    input  logic [255:0] d_data_i,
    output logic [255:0] d_data_o,
    output logic         d_ack_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic         busy_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    state_e       state_q, state_d;
    logic         last_i_q, last_i_d;
    logic         gnt_d_q, gnt_d_d;
    logic         mem_en_q, mem_en_d;
    logic         mem_we_q, mem_we_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [255:0] mem_wdata_q, mem_wdata_d;
    logic         pick_d;
    logic         mem_done;

    // D wins when it is the only requester, or when both request and I was served last
    assign pick_d   = d_enable_i && (!i_enable_i || last_i_q);
    assign mem_done = (state_q == BUSY) && mem_ack_i;

    // Next state: grant and latch in IDLE, finish on memory ack, then one DONE cycle
    always_comb begin
        state_d     = state_q;
        last_i_d    = last_i_q;
        gnt_d_d     = gnt_d_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: if (i_enable_i || d_enable_i) begin
                state_d     = BUSY;
                mem_en_d    = 1'b1;
                gnt_d_d     = pick_d;
                mem_we_d    = pick_d ? d_write_i : i_write_i;
                mem_addr_d  = pick_d ? d_addr_i  : i_addr_i;
                mem_wdata_d = pick_d ? d_data_i  : i_data_i;
            end
            BUSY: if (mem_ack_i) begin
                state_d  = DONE;
                mem_en_d = 1'b0;
                last_i_d = !gnt_d_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered memory-side outputs; reset leaves I as last grant so D wins first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_i_q    <= 1'b1;
            gnt_d_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_i_q    <= last_i_d;
            gnt_d_q     <= gnt_d_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy_o       = state_q != IDLE;
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_wdata_q;
    assign d_ack_o      = mem_done && gnt_d_q;
    assign i_ack_o      = mem_done && !gnt_d_q;
    assign d_data_o     = d_ack_o ? mem_data_i : '0;
    assign i_data_o     = i_ack_o ? mem_data_i : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and randomized model check for mem_arbiter
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst_i;
    logic         i_enable_i, i_write_i, d_enable_i, d_write_i;
    logic [31:0]  i_addr_i, d_addr_i;
    logic [255:0] i_data_i, d_data_i, i_data_o, d_data_o;
    logic         i_ack_o, d_ack_o;
    logic         mem_enable_o, mem_write_o, mem_ack_i, busy_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    int           checks = 0;
    int           errors = 0;

    localparam logic [255:0] PAT = {8{32'hCAFEF00D}};
    localparam logic [255:0] AAS = {64{4'hA}};

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .i_enable_i(i_enable_i), .i_write_i(i_write_i), .i_addr_i(i_addr_i), .i_data_i(i_data_i),
        .i_data_o(i_data_o), .i_ack_o(i_ack_o),
        .d_enable_i(d_enable_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
        .d_data_o(d_data_o), .d_ack_o(d_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .busy_o(busy_o)
    );

    typedef struct packed {
        logic        rst, ie, de, ack;
        logic        busy, men, ia, da;
        logic [31:0] addr;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs;
        i_enable_i = 0; i_write_i = 0; i_addr_i = 0; i_data_i = 0;
        d_enable_i = 0; d_write_i = 0; d_addr_i = 0; d_data_i = 0;
        mem_ack_i = 0; mem_data_i = 0;
    endtask

    task automatic do_reset;
        rst_i = 1;
        clr_inputs();
        tick();
        tick();
        rst_i = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_men"}, mem_enable_o, 0);
        chk({tag, "_mwe"}, mem_write_o, 0);
        chk({tag, "_maddr"}, mem_addr_o, 0);
        chk({tag, "_mdata"}, mem_data_o, 0);
        chk({tag, "_iack"}, i_ack_o, 0);
        chk({tag, "_dack"}, d_ack_o, 0);
        chk({tag, "_idata"}, i_data_o, 0);
        chk({tag, "_ddata"}, d_data_o, 0);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run_table;
        vec_t tbl[16];
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 1'b1, 32'h400};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h400};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h400};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h100};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 1'b0, 32'h100};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 32'h100};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 1'b1, 32'h400};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h400};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h400};
        do_reset();
        i_addr_i = 32'h100; d_addr_i = 32'h400;
        i_data_i = {8{32'h11111111}}; d_data_i = {8{32'h22222222}};
        mem_data_i = PAT;
        for (int r = 0; r < 16; r++) begin
            rst_i = tbl[r].rst; i_enable_i = tbl[r].ie; d_enable_i = tbl[r].de; mem_ack_i = tbl[r].ack;
            #1;
            chk($sformatf("tbl%0d_busy", r), busy_o, tbl[r].busy);
            chk($sformatf("tbl%0d_men", r), mem_enable_o, tbl[r].men);
            chk($sformatf("tbl%0d_iack", r), i_ack_o, tbl[r].ia);
            chk($sformatf("tbl%0d_dack", r), d_ack_o, tbl[r].da);
            chk($sformatf("tbl%0d_idata", r), i_data_o, tbl[r].ia ? PAT : 256'h0);
            chk($sformatf("tbl%0d_ddata", r), d_data_o, tbl[r].da ? PAT : 256'h0);
            chk($sformatf("tbl%0d_maddr", r), mem_addr_o, {224'h0, tbl[r].addr});
            chk($sformatf("tbl%0d_mwe", r), mem_write_o, 0);
            tick();
        end
    endtask

    task automatic seq_single_read;
        int pulses;
        pulses = 0;
        do_reset();
        chk_zero("rst");
        d_enable_i = 1; d_addr_i = 32'h0000_0400;
        tick();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("rd_wait_men", mem_enable_o, 1);
            chk("rd_wait_mwe", mem_write_o, 0);
            chk("rd_wait_dack", d_ack_o, 0);
            tick();
        end
        mem_ack_i = 1; mem_data_i = AAS;
        #1;
        pulses += int'(d_ack_o);
        chk("rd_ddata", d_data_o, AAS);
        chk("rd_maddr", mem_addr_o, 32'h400);
        chk("rd_iack", i_ack_o, 0);
        tick();
        mem_ack_i = 0; d_enable_i = 0;
        #1;
        pulses += int'(d_ack_o);
        chk("rd_done_men", mem_enable_o, 0);
        chk("rd_done_ddata", d_data_o, 0);
        tick();
        #1;
        chk("rd_pulses", pulses, 1);
        chk("rd_idle_busy", busy_o, 0);
    endtask

    task automatic seq_write_hold;
        d_enable_i = 1; d_write_i = 1; d_addr_i = 32'h20; d_data_i = 256'h1234;
        tick();
        d_addr_i = 32'hDEAD_0000; d_data_i = 256'hBEEF; d_write_i = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("wh_maddr", mem_addr_o, 32'h20);
            chk("wh_mdata", mem_data_o, 256'h1234);
            chk("wh_mwe", mem_write_o, 1);
            tick();
            d_addr_i = $urandom; d_data_i = rnd256();
        end
        mem_ack_i = 1;
        #1;
        chk("wh_ack", d_ack_o, 1);
        chk("wh_ack_maddr", mem_addr_o, 32'h20);
        tick();
        clr_inputs();
        tick();
    endtask

    task automatic seq_reset_mid;
        do_reset();
        d_enable_i = 1; d_addr_i = 32'h400;
        tick();
        tick();
        tick();
        #1;
        chk("rm_busy_before", busy_o, 1);
        rst_i = 1; d_enable_i = 0;
        tick();
        rst_i = 0;
        #1;
        chk_zero("rm");
        mem_ack_i = 1; mem_data_i = PAT;
        #1;
        chk("rm_late_dack", d_ack_o, 0);
        chk("rm_late_iack", i_ack_o, 0);
        tick();
        #1;
        chk("rm_late_busy", busy_o, 0);
        mem_ack_i = 0;
    endtask

    task automatic seq_fairness;
        logic order[6];
        int   n, last_cyc;
        n = 0; last_cyc = 0;
        for (int k = 0; k < 6; k++) order[k] = 0;
        do_reset();
        i_enable_i = 1; d_enable_i = 1; mem_ack_i = 1;
        i_addr_i = 32'h100; d_addr_i = 32'h400;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            #1;
            chk("fair_excl", d_ack_o && i_ack_o, 0);
            if (d_ack_o || i_ack_o) begin
                order[n] = d_ack_o;
                chk("fair_addr", mem_addr_o, d_ack_o ? 32'h400 : 32'h100);
                if (n > 0) chk("fair_gap", cyc - last_cyc, 3);
                last_cyc = cyc;
                n++;
            end
            tick();
        end
        chk("fair_count", n, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("fair_order%0d", k), order[k], (k % 2) == 0);
        clr_inputs();
    endtask

    task automatic run_random;
        int           owner;
        bit           cool, last_d;
        bit           pend[2];
        logic [31:0]  r_addr[2];
        logic [255:0] r_data[2];
        logic         r_we[2];
        logic [31:0]  l_addr;
        logic [255:0] l_data;
        logic         l_we;
        logic         en[2];
        owner = -1; cool = 0; last_d = 0;
        l_addr = 0; l_data = 0; l_we = 0;
        for (int p = 0; p < 2; p++) begin pend[p] = 0; r_addr[p] = 0; r_data[p] = 0; r_we[p] = 0; end
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1; r_addr[p] = $urandom; r_data[p] = rnd256(); r_we[p] = 1'($urandom_range(0, 1));
                end else if (pend[p] && owner == p) begin
                    r_addr[p] = $urandom; r_data[p] = rnd256(); r_we[p] = 1'($urandom_range(0, 1));
                end
                en[p] = pend[p];
            end
            i_enable_i = en[0]; i_addr_i = r_addr[0]; i_data_i = r_data[0]; i_write_i = r_we[0];
            d_enable_i = en[1]; d_addr_i = r_addr[1]; d_data_i = r_data[1]; d_write_i = r_we[1];
            mem_ack_i = $urandom_range(0, 3) == 0;
            mem_data_i = rnd256();
            #1;
            chk("rnd_busy", busy_o, owner >= 0 || cool);
            chk("rnd_men", mem_enable_o, owner >= 0);
            chk("rnd_iack", i_ack_o, owner == 0 && mem_ack_i);
            chk("rnd_dack", d_ack_o, owner == 1 && mem_ack_i);
            chk("rnd_idata", i_data_o, (owner == 0 && mem_ack_i) ? mem_data_i : 256'h0);
            chk("rnd_ddata", d_data_o, (owner == 1 && mem_ack_i) ? mem_data_i : 256'h0);
            if (owner >= 0) begin
                chk("rnd_maddr", mem_addr_o, l_addr);
                chk("rnd_mdata", mem_data_o, l_data);
                chk("rnd_mwe", mem_write_o, l_we);
            end
            if (owner >= 0) begin
                if (mem_ack_i) begin
                    last_d = owner == 1;
                    pend[owner] = 0;
                    owner = -1;
                    cool = 1;
                end
            end else if (cool) begin
                cool = 0;
            end else if (en[0] || en[1]) begin
                if (en[0] && en[1]) owner = last_d ? 0 : 1;
                else owner = en[1] ? 1 : 0;
                l_addr = r_addr[owner]; l_data = r_data[owner]; l_we = r_we[owner];
            end
            tick();
        end
        clr_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i = 1;
        clr_inputs();
        run_table();
        seq_single_read();
        seq_write_hold();
        seq_reset_mid();
        seq_fairness();
        run_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
